fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e : fetch controller states (BOOT, RUN, ERR)
//   INSTR_W/PC_W  : instruction and program-counter widths
//   PC_INC        : byte step between sequential instructions
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_e;

    localparam int          INSTR_W = 32;
    localparam int          PC_W    = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointers/count only)
//   push      : write i_wdata at the tail (honoured when not full, or when
//               a pop frees the head slot in the same cycle)
//   pop       : drop the head entry (ignored when empty)
//   flush     : discard all entries; wins over push and pop
//   i_wdata   : entry to write
//   o_rdata   : current head entry (storage read, no combinational input path)
//   full/empty: occupancy flags
module fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (r_count == (AW + 1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot the write pointer sits on.
    assign w_do_push = push && (!full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - 1'b1;
        end
    end

    // Storage is data only; validity is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives a tagless instruction memory, filters
// responses by comparing the registered address against the current fetch
// PC, buffers {pc, instr} pairs and hands them to decode.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem_pc         : memory byte address (fetch PC modulo IMEM_BYTES)
//   imem_rdy/instr  : one-cycle response for the previous cycle's imem_pc
//   redirect_valid/pc : branch/jump redirect (misaligned target -> ERR)
//   if_valid/ready  : decode handshake on the buffer head
//   if_instr/if_pc  : head instruction and its full 32-bit PC
//   fetch_err       : sticky misaligned-redirect flag
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 32,
    parameter int          DEPTH      = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_pc,
    input  logic               imem_rdy,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               fetch_err
);

    localparam logic [PC_W-1:0] PC_MASK = PC_W'(IMEM_BYTES - 1);

    fetch_state_e                r_state;
    fetch_state_e                w_state_nxt;
    logic [PC_W-1:0]             r_fetch_pc;
    logic [PC_W-1:0]             r_pc_d1;
    logic                        r_fetch_err;
    logic                        w_redir_ok;
    logic                        w_redir_bad;
    logic                        w_pop;
    logic                        w_accept;
    logic                        w_full;
    logic                        w_empty;
    logic [PC_W+INSTR_W-1:0]     w_head;

    assign imem_pc     = r_fetch_pc & PC_MASK;
    assign w_redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign w_redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_BOOT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            ST_BOOT: w_state_nxt = w_redir_bad ? ST_ERR : ST_RUN;
            ST_RUN: begin
                if (w_redir_bad) w_state_nxt = ST_ERR;
                w_pop    = !w_empty && if_ready && !redirect_valid;
                // The memory has no request tag: a response belongs to us
                // only if the address it was fetched for is still current.
                w_accept = imem_rdy && (r_pc_d1 == imem_pc) && !redirect_valid &&
                           (!w_full || w_pop);
            end
            ST_ERR:  if (w_redir_ok) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_pc_d1     <= RESET_PC & PC_MASK;
            r_fetch_err <= 1'b0;
        end else begin
            r_pc_d1 <= imem_pc;
            if (w_redir_ok) begin
                r_fetch_pc  <= redirect_pc;
                r_fetch_err <= 1'b0;
            end else if (w_redir_bad) begin
                r_fetch_err <= 1'b1;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + PC_INC;
            end
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (PC_W + INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_accept),
        .pop     (w_pop),
        .flush   (redirect_valid),
        .i_wdata ({r_fetch_pc, imem_instr}),
        .o_rdata (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Head fields read as zero while the buffer holds nothing valid.
    assign if_valid  = !w_empty;
    assign if_pc     = w_empty ? '0 : w_head[PC_W+INSTR_W-1:INSTR_W];
    assign if_instr  = w_empty ? '0 : w_head[INSTR_W-1:0];
    assign fetch_err = r_fetch_err;

endmodule
